axi_burst_master: RTL and testbench

//  Parametrised AXI3/4 master between the cache controllers and the AXI bus. Runs one read burst
//  (line refill) and one write burst (line write-back) concurrently, each up to MAX_BEATS beats.

---
 rtl/axi_burst_master.sv | 263 ++++++++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master.sv
// AXI3/4 burst master: one read burst (line refill) and one write burst (write-back) in flight
// concurrently, with a drain-style read cancel and optional read-after-write ordering.
module axi_burst_master #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BEATS = 8,
    parameter int unsigned AXI_ID    = 0,
    parameter int unsigned RAW_ORDER = 1,
    localparam int unsigned STRB_W   = DATA_W / 8,
    localparam int unsigned LW       = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1,
    localparam int unsigned ID_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    // read request side
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [LW-1:0]     rd_len,
    input  logic [2:0]        rd_size,
    output logic              rd_ack,
    input  logic              rd_cancel,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              rd_err,
    // write request side
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LW-1:0]     wr_len,
    input  logic [2:0]        wr_size,
    output logic              wr_ack,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb,
    output logic              wr_pop,
    output logic              wr_done,
    output logic              wr_err,
    // AXI read address / data
    output logic [ID_W-1:0]   arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    // AXI write address / data / response
    output logic [ID_W-1:0]   awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awlock,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    output logic [ID_W-1:0]   wid,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [1:0] {RIdle, RAddr, RData} r_state_e;
    typedef enum logic [1:0] {WIdle, WXfer, WResp} w_state_e;

    r_state_e          r_state_q, r_state_d;
    logic [ADDR_W-1:0] r_addr_q;
    logic [LW-1:0]     r_len_q;
    logic [2:0]        r_size_q;
    logic [LW:0]       r_cnt_q;
    logic              r_discard_q, r_err_q;
    logic              r_accept, r_beat;

    w_state_e          w_state_q, w_state_d;
    logic [ADDR_W-1:0] w_addr_q;
    logic [LW-1:0]     w_len_q;
    logic [2:0]        w_size_q;
    logic [LW:0]       w_cnt_q;
    logic              aw_done_q, w_last_q;
    logic              w_accept, aw_hs, w_hs, w_is_last, aw_fin, w_fin;

    logic              unused_resp;
    assign unused_resp = ^{rresp[0], bresp[0]};

    // ---------------- read FSM ----------------
    assign r_accept = (r_state_q == RIdle) && rd_req &&
                      ((RAW_ORDER == 0) || (w_state_q == WIdle));
    assign r_beat   = (r_state_q == RData) && rvalid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state_q <= RIdle;
        else       r_state_q <= r_state_d;
    end

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            RIdle:   if (r_accept) r_state_d = RAddr;
            RAddr:   if (arready) r_state_d = RData;
            RData:   if (rvalid && rlast) r_state_d = RIdle;
            default: r_state_d = RIdle;
        endcase
    end

    // A cancel seen in the same cycle as a beat already hides that beat.
    always_comb begin
        rd_ack   = 1'b0;
        arvalid  = 1'b0;
        rready   = 1'b0;
        rd_valid = 1'b0;
        rd_last  = 1'b0;
        rd_err   = 1'b0;
        unique case (r_state_q)
            RIdle: rd_ack = r_accept;
            RAddr: arvalid = 1'b1;
            RData: begin
                rready = 1'b1;
                if (rvalid && !r_discard_q && !rd_cancel) begin
                    rd_valid = 1'b1;
                    rd_last  = rlast;
                    rd_err   = rlast && (r_err_q || rresp[1]);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr_q    <= '0;
            r_len_q     <= '0;
            r_size_q    <= '0;
            r_cnt_q     <= '0;
            r_err_q     <= 1'b0;
            r_discard_q <= 1'b0;
        end else begin
            if (r_accept) begin
                r_addr_q <= rd_addr;
                r_len_q  <= rd_len;
                r_size_q <= rd_size;
                r_cnt_q  <= '0;
                r_err_q  <= 1'b0;
            end
            if (r_beat) begin
                r_cnt_q <= r_cnt_q + 1'b1;
                r_err_q <= r_err_q | rresp[1];
            end
            if (r_state_d == RIdle)                      r_discard_q <= 1'b0;
            else if (rd_cancel && (r_state_q != RIdle))  r_discard_q <= 1'b1;
        end
    end

    rlast_on_final_beat: assert property (@(posedge clk) disable iff (reset)
        r_beat |-> (rlast == (r_cnt_q == {1'b0, r_len_q})));

    // ---------------- write FSM ----------------
    assign w_accept  = (w_state_q == WIdle) && wr_req;
    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign w_is_last = (w_cnt_q == {1'b0, w_len_q});
    assign aw_fin    = aw_done_q || aw_hs;
    assign w_fin     = w_last_q || (w_hs && w_is_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) w_state_q <= WIdle;
        else       w_state_q <= w_state_d;
    end

    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            WIdle:   if (w_accept) w_state_d = WXfer;
            WXfer:   if (aw_fin && w_fin) w_state_d = WResp;
            WResp:   if (bvalid) w_state_d = WIdle;
            default: w_state_d = WIdle;
        endcase
    end

    always_comb begin
        wr_ack  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        wr_done = 1'b0;
        wr_err  = 1'b0;
        unique case (w_state_q)
            WIdle: wr_ack = w_accept;
            WXfer: begin
                awvalid = !aw_done_q;
                wvalid  = !w_last_q;
            end
            WResp: begin
                bready  = 1'b1;
                wr_done = bvalid;
                wr_err  = bvalid && bresp[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_cnt_q   <= '0;
            aw_done_q <= 1'b0;
            w_last_q  <= 1'b0;
        end else begin
            if (w_accept) begin
                w_addr_q  <= wr_addr;
                w_len_q   <= wr_len;
                w_size_q  <= wr_size;
                w_cnt_q   <= '0;
                aw_done_q <= 1'b0;
                w_last_q  <= 1'b0;
            end
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs) begin
                w_cnt_q <= w_cnt_q + 1'b1;
                if (w_is_last) w_last_q <= 1'b1;
            end
        end
    end

    // ---------------- constant / pass-through channel fields ----------------
    assign arid    = ID_W'(AXI_ID);
    assign araddr  = r_addr_q;
    assign arlen   = {{(8 - LW){1'b0}}, r_len_q};
    assign arsize  = r_size_q;
    assign arburst = 2'b01;
    assign arlock  = 1'b0;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign rd_data = rdata;

    assign awid    = ID_W'(AXI_ID);
    assign awaddr  = w_addr_q;
    assign awlen   = {{(8 - LW){1'b0}}, w_len_q};
    assign awsize  = w_size_q;
    assign awburst = 2'b01;
    assign awlock  = 1'b0;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign wid     = ID_W'(AXI_ID);
    assign wdata   = wr_data;
    assign wstrb   = wr_strb;
    assign wlast   = wvalid && w_is_last;
    assign wr_pop  = w_hs;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed scenarios plus a randomised AXI slave / requester, all checked every cycle against a
// transaction-level model of the burst master kept in this bench.
module tb_axi_burst_master;
    localparam int ADDR_W = 32, DATA_W = 32, LW = 3, STRB_W = 4, ID_W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              rd_req, rd_ack, rd_cancel, rd_valid, rd_last, rd_err;
    logic [ADDR_W-1:0] rd_addr, wr_addr, araddr, awaddr;
    logic [LW-1:0]     rd_len, wr_len;
    logic [2:0]        rd_size, wr_size, arsize, awsize, arprot, awprot;
    logic [DATA_W-1:0] rd_data, wr_data, rdata, wdata;
    logic              wr_req, wr_ack, wr_pop, wr_done, wr_err;
    logic [STRB_W-1:0] wr_strb, wstrb;
    logic [ID_W-1:0]   arid, awid, wid;
    logic [7:0]        arlen, awlen;
    logic [1:0]        arburst, awburst, rresp, bresp;
    logic [3:0]        arcache, awcache;
    logic              arlock, awlock, arvalid, arready, rlast, rvalid, rready;
    logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    axi_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(8), .AXI_ID(0),
                       .RAW_ORDER(1)) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_size(rd_size), .rd_ack(rd_ack),
        .rd_cancel(rd_cancel), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .rd_err(rd_err),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_size(wr_size), .wr_ack(wr_ack),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_pop(wr_pop), .wr_done(wr_done), .wr_err(wr_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    // Second instance without read-after-write ordering; slave side tied off.
    logic              n_rd_req, n_wr_req, n_rd_ack, n_wr_ack, n_rd_valid, n_rd_last, n_rd_err;
    logic              n_wr_pop, n_wr_done, n_wr_err, n_arlock, n_awlock, n_arvalid, n_rready;
    logic              n_awvalid, n_wlast, n_wvalid, n_bready;
    logic [DATA_W-1:0] n_rd_data, n_wdata;
    logic [ID_W-1:0]   n_arid, n_awid, n_wid;
    logic [ADDR_W-1:0] n_araddr, n_awaddr;
    logic [7:0]        n_arlen, n_awlen;
    logic [2:0]        n_arsize, n_awsize, n_arprot, n_awprot;
    logic [1:0]        n_arburst, n_awburst;
    logic [3:0]        n_arcache, n_awcache;
    logic [STRB_W-1:0] n_wstrb;

    axi_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(8), .AXI_ID(0),
                       .RAW_ORDER(0)) dut_noraw (
        .clk(clk), .reset(reset),
        .rd_req(n_rd_req), .rd_addr(32'h8000), .rd_len(3'd0), .rd_size(3'd2), .rd_ack(n_rd_ack),
        .rd_cancel(1'b0), .rd_data(n_rd_data), .rd_valid(n_rd_valid), .rd_last(n_rd_last),
        .rd_err(n_rd_err),
        .wr_req(n_wr_req), .wr_addr(32'h9000), .wr_len(3'd0), .wr_size(3'd2), .wr_ack(n_wr_ack),
        .wr_data(32'h0), .wr_strb(4'hF), .wr_pop(n_wr_pop), .wr_done(n_wr_done),
        .wr_err(n_wr_err),
        .arid(n_arid), .araddr(n_araddr), .arlen(n_arlen), .arsize(n_arsize),
        .arburst(n_arburst), .arlock(n_arlock), .arcache(n_arcache), .arprot(n_arprot),
        .arvalid(n_arvalid), .arready(1'b0), .rdata(32'h0), .rresp(2'b00), .rlast(1'b0),
        .rvalid(1'b0), .rready(n_rready),
        .awid(n_awid), .awaddr(n_awaddr), .awlen(n_awlen), .awsize(n_awsize),
        .awburst(n_awburst), .awlock(n_awlock), .awcache(n_awcache), .awprot(n_awprot),
        .awvalid(n_awvalid), .awready(1'b1), .wid(n_wid), .wdata(n_wdata), .wstrb(n_wstrb),
        .wlast(n_wlast), .wvalid(n_wvalid), .wready(1'b1), .bresp(2'b00), .bvalid(1'b0),
        .bready(n_bready)
    );

    int checks = 0;
    int failures = 0;

    // Transaction-level model: one outstanding read, one outstanding write.
    bit        m_r_busy, m_ar_done, m_discard, m_r_err;
    int        m_r_len;
    logic [31:0] m_r_addr;
    logic [2:0]  m_r_size;
    bit        m_w_busy, m_aw_done;
    int        m_w_len, m_w_beats;
    logic [31:0] m_w_addr;
    logic [2:0]  m_w_size;

    bit ev_rack, ev_wack, ev_ar, ev_r, ev_aw, ev_pop, ev_wlast, ev_b;
    int c_arvalid, c_rd_ack, c_wr_ack, c_rd_valid, c_rd_last, c_rbeat;
    int c_wr_pop, c_wlast, c_wlast_at, c_wr_done, c_wr_err;
    logic [31:0] last_araddr, last_awaddr, last_rd_data_last;
    logic [7:0]  last_arlen, last_awlen;

    // Random slave state.
    int s_r_left;
    bit s_aw, s_wl;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic clr_counts();
        c_arvalid = 0; c_rd_ack = 0; c_wr_ack = 0; c_rd_valid = 0; c_rd_last = 0; c_rbeat = 0;
        c_wr_pop = 0; c_wlast = 0; c_wlast_at = 0; c_wr_done = 0; c_wr_err = 0;
    endtask

    task automatic clear_all();
        m_r_busy = 0; m_ar_done = 0; m_discard = 0; m_r_err = 0; m_w_busy = 0; m_aw_done = 0;
        m_w_beats = 0; s_r_left = 0; s_aw = 0; s_wl = 0;
        rd_req = 0; rd_cancel = 0; wr_req = 0; arready = 0; rvalid = 0; rlast = 0;
        rresp = 0; rdata = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
    endtask

    // One clock cycle: inputs already driven at the falling edge; compare, then advance model.
    task automatic step();
        bit e_rack, e_wack, e_arv, e_rrdy, e_beat, e_rdv, e_rdl, e_rde;
        bit e_resp, e_awv, e_wv, e_wl, e_pop, e_done, e_err;
        #2;
        e_rack = rd_req && !m_r_busy && !m_w_busy;
        e_wack = wr_req && !m_w_busy;
        e_arv  = m_r_busy && !m_ar_done;
        e_rrdy = m_r_busy && m_ar_done;
        e_beat = e_rrdy && rvalid;
        e_rdv  = e_beat && !m_discard && !rd_cancel;
        e_rdl  = e_rdv && rlast;
        e_rde  = e_rdl && (m_r_err || rresp[1]);
        e_resp = m_w_busy && m_aw_done && (m_w_beats == m_w_len + 1);
        e_awv  = m_w_busy && !m_aw_done;
        e_wv   = m_w_busy && (m_w_beats <= m_w_len);
        e_wl   = e_wv && (m_w_beats == m_w_len);
        e_pop  = e_wv && wready;
        e_done = e_resp && bvalid;
        e_err  = e_done && bresp[1];

        chk("rd_ack", rd_ack, e_rack);
        chk("wr_ack", wr_ack, e_wack);
        chk("arvalid", arvalid, e_arv);
        chk("rready", rready, e_rrdy);
        chk("rd_valid", rd_valid, e_rdv);
        chk("rd_last", rd_last, e_rdl);
        chk("rd_err", rd_err, e_rde);
        chk("awvalid", awvalid, e_awv);
        chk("wvalid", wvalid, e_wv);
        chk("wr_pop", wr_pop, e_pop);
        chk("bready", bready, e_resp);
        chk("wr_done", wr_done, e_done);
        chk("wr_err", wr_err, e_err);
        if (e_arv) begin
            chk("araddr", araddr, m_r_addr);
            chk("arlen", arlen, m_r_len);
            chk("arsize", arsize, m_r_size);
            chk("ar_fixed", {arburst, arid, arlock, arcache, arprot}, {2'b01, 12'h0});
        end
        if (e_rdv) chk("rd_data", rd_data, rdata);
        if (e_awv) begin
            chk("awaddr", awaddr, m_w_addr);
            chk("awlen", awlen, m_w_len);
            chk("awsize", awsize, m_w_size);
            chk("aw_fixed", {awburst, awid, awlock, awcache, awprot}, {2'b01, 12'h0});
        end
        if (e_wv) begin
            chk("wlast", wlast, e_wl);
            chk("wdata", {wid, wstrb, wdata}, {4'h0, wr_strb, wr_data});
        end

        if (arvalid) begin c_arvalid++; last_araddr = araddr; last_arlen = arlen; end
        if (awvalid) begin last_awaddr = awaddr; last_awlen = awlen; end
        if (rd_ack) c_rd_ack++;
        if (wr_ack) c_wr_ack++;
        if (rvalid && rready) c_rbeat++;
        if (rd_valid) c_rd_valid++;
        if (rd_last) begin c_rd_last++; last_rd_data_last = rd_data; end
        if (wvalid && wready) begin
            c_wr_pop++;
            if (wlast) begin c_wlast++; c_wlast_at = c_wr_pop; end
        end
        if (wr_done) c_wr_done++;
        if (wr_err) c_wr_err++;

        @(posedge clk);
        ev_rack = e_rack; ev_wack = e_wack; ev_ar = e_arv && arready; ev_r = e_beat;
        ev_aw = e_awv && awready; ev_pop = e_pop; ev_wlast = e_pop && e_wl; ev_b = e_done;
        if (e_rack) begin
            m_r_busy = 1; m_ar_done = 0; m_discard = 0; m_r_err = 0;
            m_r_addr = rd_addr; m_r_len = int'(rd_len); m_r_size = rd_size;
        end else if (m_r_busy) begin
            if (ev_ar) m_ar_done = 1;
            if (rd_cancel) m_discard = 1;
            if (e_beat) begin
                m_r_err = m_r_err | rresp[1];
                if (rlast) begin m_r_busy = 0; m_discard = 0; end
            end
        end
        if (e_wack) begin
            m_w_busy = 1; m_aw_done = 0; m_w_beats = 0;
            m_w_addr = wr_addr; m_w_len = int'(wr_len); m_w_size = wr_size;
        end else if (m_w_busy) begin
            if (ev_aw) m_aw_done = 1;
            if (e_pop) m_w_beats++;
            if (e_done) m_w_busy = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit drained;
        reset = 1'b1;
        clear_all();
        rd_addr = 0; rd_len = 0; rd_size = 0; wr_addr = 0; wr_len = 0; wr_size = 0;
        wr_data = 32'hCAFE_0000; wr_strb = 4'hF;
        n_rd_req = 0; n_wr_req = 0;
        repeat (2) @(negedge clk);
        #2;
        chk("reset_valids", {arvalid, awvalid, wvalid, rready, bready, rd_valid, wr_pop}, 7'b0);
        chk("reset_addr", {araddr, awaddr, arlen, awlen}, 80'h0);
        @(negedge clk);
        reset = 1'b0;
        clr_counts();
        step();

        // 1: read 0x1000 len 3, arready 2 cycles late
        clr_counts();
        rd_req = 1; rd_addr = 32'h1000; rd_len = 3; rd_size = 2;
        step();
        rd_req = 0;
        step(); step();
        arready = 1; step(); arready = 0;
        for (int i = 0; i < 4; i++) begin
            rvalid = 1; rdata = 32'h11 * (i + 1); rlast = (i == 3); rresp = 0;
            step();
        end
        rvalid = 0; rlast = 0;
        chk("t1_arvalid_cycles", c_arvalid, 3);
        chk("t1_arlen", last_arlen, 3);
        chk("t1_araddr", last_araddr, 32'h1000);
        chk("t1_rd_valid", c_rd_valid, 4);
        chk("t1_rd_last", c_rd_last, 1);
        chk("t1_last_data", last_rd_data_last, 32'h44);

        // 2: 8-beat read, cancel with beat 2
        clr_counts();
        rd_req = 1; rd_addr = 32'h2000; rd_len = 7; arready = 1;
        step();
        rd_req = 0;
        step(); arready = 0;
        for (int i = 0; i < 8; i++) begin
            rvalid = 1; rdata = 32'hA0 + i; rlast = (i == 7); rd_cancel = (i == 1);
            step();
        end
        rvalid = 0; rlast = 0; rd_cancel = 0;
        chk("t2_rd_valid", c_rd_valid, 1);
        chk("t2_rd_last", c_rd_last, 0);
        chk("t2_beats_drained", c_rbeat, 8);
        clr_counts();
        rd_req = 1; rd_addr = 32'h3000; rd_len = 0;
        step();
        chk("t2_next_ack", c_rd_ack, 1);
        chk("t2_no_ar_in_ack", c_arvalid, 0);
        rd_req = 0; arready = 1;
        step(); arready = 0;
        chk("t2_next_arvalid", c_arvalid, 1);
        rvalid = 1; rlast = 1; rdata = 32'h77; step(); rvalid = 0; rlast = 0;
        chk("t2_next_rd_last", c_rd_last, 1);

        // 3: 8-beat write, toggling wready, late awready, SLVERR response
        clr_counts();
        wr_req = 1; wr_addr = 32'h4000; wr_len = 7; wr_size = 2; wr_data = $urandom;
        step();
        wr_req = 0;
        for (int cyc = 0; cyc < 60 && c_wr_done == 0; cyc++) begin
            wready  = cyc[0];
            awready = (c_wr_pop >= 5);
            bvalid  = m_w_busy && m_aw_done && (m_w_beats == 8);
            bresp   = 2'b10;
            step();
            if (ev_pop) begin wr_data = $urandom; wr_strb = 4'($urandom); end
        end
        bvalid = 0; bresp = 0; awready = 0; wready = 0;
        chk("t3_pops", c_wr_pop, 8);
        chk("t3_wlast_count", c_wlast, 1);
        chk("t3_wlast_beat", c_wlast_at, 8);
        chk("t3_wr_done", c_wr_done, 1);
        chk("t3_wr_err", c_wr_err, 1);
        chk("t3_awlen", last_awlen, 7);

        // 4: read-after-write ordering
        clr_counts();
        wr_req = 1; wr_addr = 32'h5000; wr_len = 0;
        step();
        wr_req = 0; awready = 1; wready = 1;
        step();
        awready = 0; wready = 0;
        rd_req = 1; rd_addr = 32'h6000; rd_len = 0;
        repeat (3) step();
        chk("t4_blocked_ack", c_rd_ack, 0);
        bvalid = 1; step(); bvalid = 0;
        chk("t4_wr_done", c_wr_done, 1);
        chk("t4_no_ack_with_done", c_rd_ack, 0);
        step();
        chk("t4_ack_after_done", c_rd_ack, 1);
        chk("t4_no_early_ar", c_arvalid, 0);
        rd_req = 0; arready = 1; step(); arready = 0;
        rvalid = 1; rlast = 1; step(); rvalid = 0; rlast = 0;
        n_wr_req = 1;
        #2 chk("t4n_wr_ack", n_wr_ack, 1'b1);
        @(negedge clk); n_wr_req = 0;
        @(negedge clk); n_rd_req = 1;
        #2 chk("t4n_in_resp", n_bready, 1'b1);
        chk("t4n_rd_ack", n_rd_ack, 1'b1);
        @(negedge clk); n_rd_req = 0;
        #2 chk("t4n_arvalid", n_arvalid, 1'b1);
        @(negedge clk);

        // 5: reset in the middle of both bursts
        clr_counts();
        rd_req = 1; rd_addr = 32'h7000; rd_len = 7; wr_req = 1; wr_addr = 32'h7800; wr_len = 7;
        step();
        rd_req = 0; wr_req = 0; arready = 1; wready = 1;
        step();
        arready = 0; rvalid = 1; rdata = 32'h55; rlast = 0;
        step();
        #1 chk("t5_pre", {rd_valid, wvalid, awvalid}, 3'b111);
        reset = 1'b1;
        #1 chk("t5_post", {arvalid, awvalid, wvalid, rd_valid, rready, wr_pop, bready}, 7'b0);
        chk("t5_no_done", {wr_done, rd_last}, 2'b00);
        clear_all();
        @(negedge clk); reset = 1'b0;
        step(); step();

        // 6: simultaneous single-beat read and write
        clr_counts();
        rd_req = 1; rd_len = 0; wr_req = 1; wr_len = 0;
        step();
        chk("t6_acks", {c_rd_ack[1:0], c_wr_ack[1:0]}, 4'b0101);
        rd_req = 0; wr_req = 0; arready = 1; awready = 1; wready = 1;
        step();
        arready = 0; awready = 0; wready = 0;
        rvalid = 1; rlast = 1; rdata = 32'h66; bvalid = 1;
        step();
        rvalid = 0; rlast = 0; bvalid = 0;
        step();
        chk("t6_rd_last", c_rd_last, 1);
        chk("t6_wr_done", c_wr_done, 1);
        chk("t6_wlast_first", c_wlast_at, 1);

        // Randomised traffic, then drain
        drained = 0;
        for (int cyc = 0; cyc < 3600; cyc++) begin
            bit gen;
            gen = (cyc < 3000);
            if (!gen && !rd_req && !wr_req && !m_r_busy && !m_w_busy) begin
                drained = 1;
                break;
            end
            if (gen && !rd_req && $urandom_range(3) == 0) begin
                rd_req = 1; rd_addr = $urandom; rd_len = 3'($urandom_range(7));
                rd_size = 3'($urandom_range(2));
            end
            if (gen && !wr_req && $urandom_range(3) == 0) begin
                wr_req = 1; wr_addr = $urandom; wr_len = 3'($urandom_range(7));
                wr_size = 3'($urandom_range(2));
            end
            rd_cancel = gen && ($urandom_range(15) == 0);
            arready = 1'($urandom_range(1));
            awready = 1'($urandom_range(1));
            wready  = ($urandom_range(3) != 0);
            if (s_r_left > 0 && !rvalid && $urandom_range(2) != 0) begin
                rvalid = 1; rdata = $urandom; rresp = 2'($urandom_range(3)); rlast = (s_r_left == 1);
            end
            if (s_aw && s_wl && !bvalid && $urandom_range(1) == 1) begin
                bvalid = 1; bresp = 2'($urandom_range(3));
            end
            step();
            if (ev_rack) rd_req = 0;
            if (ev_wack) wr_req = 0;
            if (ev_ar) s_r_left = m_r_len + 1;
            if (ev_r) begin rvalid = 0; rlast = 0; s_r_left--; end
            if (ev_aw) s_aw = 1;
            if (ev_wlast) s_wl = 1;
            if (ev_pop) begin wr_data = $urandom; wr_strb = 4'($urandom); end
            if (ev_b) begin bvalid = 0; s_aw = 0; s_wl = 0; end
        end
        chk("random_drained", drained, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
